// File: rtl/ram_if_pkg.sv
// Shared encodings for the RAM master: access sizes, FSM states and the
// alignment rule that decides whether an access is legal.
package ram_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  // Misaligned halves/words and the reserved size code are all errors.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = offset[0];
      SZ_WORD: access_err = (offset != 2'b00);
      default: access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_master_if.sv
// Requester-side handshake bundle of the RAM master: request fields and the
// one-cycle response.
interface ram_master_if #(
  parameter int ADDR_WIDTH = 15
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_lane_align.sv
// Combinational lane logic: byte-lane selects, store-data replication and
// little-endian load extraction with zero/sign extension.
module ram_lane_align
  import ram_if_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  lane_sel,
  output logic        err,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [3:0]  lanes_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection; an erroneous access selects nothing.
  always_comb begin
    err     = access_err(size, offset);
    lanes_s = 4'b0000;
    case (size)
      SZ_BYTE: lanes_s = 4'b0001 << offset;
      SZ_HALF: lanes_s = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lanes_s = 4'b1111;
      default: lanes_s = 4'b0000;
    endcase
    if (err) begin
      lane_sel = 4'b0000;
    end else begin
      lane_sel = lanes_s;
    end
  end

  // Store replication so every lane carries the right bytes.
  always_comb begin
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  end

  // Load extraction and right-justification.
  always_comb begin
    case (offset)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    half_s = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & byte_s[7]}}, byte_s};
      SZ_HALF: load_data = {{16{is_signed & half_s[15]}}, half_s};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/ram_master.sv
// Single-outstanding RAM access master: IDLE -> ACCESS -> RESP, driving a
// byte-laned synchronous RAM with one-cycle read latency.
module ram_master
  import ram_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_master_if.slave           req_bus,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_cs_n,
  output logic [3:0]            mem_we_n,
  output logic [31:0]           mem_data_o,
  input  logic [31:0]           mem_data_i
);

  logic [1:0]            state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [1:0]            size_r;
  logic                  we_r;
  logic                  signed_r;
  logic [31:0]           wdata_r;

  logic                  accept_s;
  logic                  access_s;
  logic                  resp_s;
  logic [3:0]            lane_sel_s;
  logic                  err_s;
  logic [31:0]           store_data_s;
  logic [31:0]           load_data_s;

  assign req_bus.req_ready = (state_r == ST_IDLE) & ~reset;
  assign accept_s          = req_bus.req_valid & req_bus.req_ready;

  // FSM sequencing and capture of the request at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      addr_r   <= '0;
      size_r   <= 2'b00;
      we_r     <= 1'b0;
      signed_r <= 1'b0;
      wdata_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r  <= ST_ACCESS;
            addr_r   <= req_bus.req_addr;
            size_r   <= req_bus.req_size;
            we_r     <= req_bus.req_we;
            signed_r <= req_bus.req_signed;
            wdata_r  <= req_bus.req_wdata;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_ACCESS: state_r <= ST_RESP;
        ST_RESP:   state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

  ram_lane_align u_align (
    .size       (size_r),
    .offset     (addr_r[1:0]),
    .is_signed  (signed_r),
    .wdata      (wdata_r),
    .rdata      (mem_data_i),
    .lane_sel   (lane_sel_s),
    .err        (err_s),
    .store_data (store_data_s),
    .load_data  (load_data_s)
  );

  // Reset gates the strobes combinationally so an aborted store never writes.
  assign access_s   = (state_r == ST_ACCESS) & ~reset;
  assign resp_s     = (state_r == ST_RESP) & ~reset;

  assign mem_addr   = addr_r[ADDR_WIDTH-1:2];
  assign mem_data_o = store_data_s;
  assign mem_cs_n   = access_s ? ~lane_sel_s : 4'b1111;
  assign mem_we_n   = we_r ? mem_cs_n : 4'b1111;

  assign req_bus.rsp_valid = resp_s;
  assign req_bus.rsp_err   = resp_s & err_s;
  assign req_bus.rsp_rdata = (resp_s & ~we_r & ~err_s) ? load_data_s : 32'h0000_0000;

endmodule
